// File: rtl/seg7_scan_driver_if.sv
// Bus between the scrolling-word source and the 7-segment scan driver.
// The master drives the word, masks and enable; the slave (scan driver) returns the pin-level outputs.
interface seg7_scan_driver_if #(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned DATA_WIDTH = 4 * NUM_DIGITS
);
  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic                  enable;
  logic [DATA_WIDTH-1:0] binary_in;
  logic [NUM_DIGITS-1:0] digit_mask;
  logic [NUM_DIGITS-1:0] dp_in;
  logic [6:0]            seg_out;
  logic                  dp_out;
  logic [NUM_DIGITS-1:0] an_out;
  logic [IdxW-1:0]       digit_idx;
  logic                  frame_start;

  modport master (
    output enable, binary_in, digit_mask, dp_in,
    input  seg_out, dp_out, an_out, digit_idx, frame_start
  );

  modport slave (
    input  enable, binary_in, digit_mask, dp_in,
    output seg_out, dp_out, an_out, digit_idx, frame_start
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scan driver.
// Snapshots the packed hex word once per frame, then drives each digit for a dwell period
// followed by an optional all-off blanking gap. All outputs are registered and reflect
// the state occupied in the current cycle.
module seg7_scan_driver #(
  parameter int unsigned NUM_DIGITS     = 8,
  parameter int unsigned DATA_WIDTH     = 4 * NUM_DIGITS,
  parameter int unsigned DWELL_TICKS    = 16,
  parameter int unsigned BLANK_TICKS    = 2,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input logic               clk_out,
  input logic               reset,
  seg7_scan_driver_if.slave bus
);

  localparam int unsigned IdxW     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned MaxTicks = (DWELL_TICKS > BLANK_TICKS) ? DWELL_TICKS : BLANK_TICKS;
  localparam int unsigned CntW     = (MaxTicks > 0) ? $clog2(MaxTicks + 1) : 1;

  localparam logic [CntW-1:0] DwellLast = CntW'(DWELL_TICKS - 1);
  // Unreachable when BLANK_TICKS is 0; the truncated value is never compared.
  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_TICKS - 1);
  localparam logic [IdxW-1:0] LastIdx   = IdxW'(NUM_DIGITS - 1);

  localparam logic [NUM_DIGITS-1:0] AnOff  = AN_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : '0;
  localparam logic [6:0]            SegOff = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic                  DpOff  = SEG_ACTIVE_LOW;

  typedef enum logic [1:0] {StIdle, StLoad, StDrive, StBlank} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [NUM_DIGITS-1:0] mask_q, mask_d;
  logic [NUM_DIGITS-1:0] dpsn_q, dpsn_d;
  logic                  end_of_digit;

  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  fs_q, fs_d;
  logic [NUM_DIGITS-1:0] onehot;
  logic [3:0]            nibble;

  // Hex to segments, active-high, bit order gfedcba.
  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      4'hF: s = 7'h71;
    endcase
    return s;
  endfunction

  // State, tick counter, digit index and frame snapshot registers.
  always_ff @(posedge clk_out or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      mask_q  <= '0;
      dpsn_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      mask_q  <= mask_d;
      dpsn_q  <= dpsn_d;
    end
  end

  // Next-state: frame sequencing, dwell/blank timing, snapshot capture.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    word_d       = word_q;
    mask_d       = mask_q;
    dpsn_d       = dpsn_q;
    end_of_digit = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.enable) state_d = StLoad;
      end
      StLoad: begin
        word_d  = bus.binary_in;
        mask_d  = bus.digit_mask;
        dpsn_d  = bus.dp_in;
        idx_d   = '0;
        cnt_d   = '0;
        state_d = StDrive;
      end
      StDrive: begin
        if (cnt_q == DwellLast) begin
          cnt_d = '0;
          if (BLANK_TICKS > 0) state_d = StBlank;
          else                 end_of_digit = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StBlank: begin
        if (cnt_q == BlankLast) begin
          cnt_d        = '0;
          end_of_digit = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    // Enable is only consulted here and in idle, so a frame always completes.
    if (end_of_digit) begin
      if (idx_q == LastIdx) begin
        idx_d   = '0;
        state_d = bus.enable ? StLoad : StIdle;
      end else begin
        idx_d   = idx_q + 1'b1;
        state_d = StDrive;
      end
    end
  end

  // Output decode from the next state so the registered pins match the occupied state.
  always_comb begin
    an_d   = AnOff;
    seg_d  = SegOff;
    dp_d   = DpOff;
    fs_d   = 1'b0;
    onehot = '0;
    onehot[idx_d] = 1'b1;
    nibble = word_d[{idx_d, 2'b00} +: 4];
    if (state_d == StDrive) begin
      seg_d = SEG_ACTIVE_LOW ? ~decode(nibble) : decode(nibble);
      dp_d  = dpsn_d[idx_d] ^ SEG_ACTIVE_LOW;
      // Masked digits still get segment data; only the anode stays dark.
      if (mask_d[idx_d]) an_d = AN_ACTIVE_LOW ? ~onehot : onehot;
      fs_d  = (state_q == StLoad);
    end
  end

  // Output registers; asynchronous reset forces every pin off immediately.
  always_ff @(posedge clk_out or negedge reset) begin
    if (!reset) begin
      an_q  <= AnOff;
      seg_q <= SegOff;
      dp_q  <= DpOff;
      fs_q  <= 1'b0;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
      fs_q  <= fs_d;
    end
  end

  assign bus.an_out      = an_q;
  assign bus.seg_out     = seg_q;
  assign bus.dp_out      = dp_q;
  assign bus.frame_start = fs_q;
  assign bus.digit_idx   = idx_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: default 8-digit instance plus a 4-digit no-gap instance.
module tb_seg7_scan_driver;

  logic clk_out = 1'b0;
  logic reset   = 1'b1;
  int   cyc     = 0;
  int   checks  = 0;
  int   errors  = 0;

  localparam logic [19:0] Off8 = {8'hFF, 7'h7F, 1'b1, 3'd0, 1'b0};
  localparam logic [14:0] Off4 = {4'hF, 7'h7F, 1'b1, 2'd0, 1'b0};

  seg7_scan_driver_if #(.NUM_DIGITS(8)) bus8 ();
  seg7_scan_driver_if #(.NUM_DIGITS(4)) bus4 ();

  seg7_scan_driver u_dut8 (
    .clk_out (clk_out),
    .reset   (reset),
    .bus     (bus8.slave)
  );

  seg7_scan_driver #(
    .NUM_DIGITS  (4),
    .DWELL_TICKS (4),
    .BLANK_TICKS (0)
  ) u_dut4 (
    .clk_out (clk_out),
    .reset   (reset),
    .bus     (bus4.slave)
  );

  always #5 clk_out = ~clk_out;
  always @(posedge clk_out) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  // Segment table from the decode list, active-high gfedcba.
  function automatic logic [6:0] dec(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return t[n];
  endfunction

  // Expected {an, seg, dp, idx, frame_start} for the 8-digit default instance.
  function automatic logic [19:0] exp_vec(input logic [31:0] w, input logic [7:0] m,
                                          input logic [7:0] p, input int d, input bit blank,
                                          input bit fs);
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] nib;
    nib = w[4*d +: 4];
    if (blank) begin
      an = 8'hFF; seg = 7'h7F; dp = 1'b1;
    end else begin
      an  = m[d] ? ~(8'h01 << d) : 8'hFF;
      seg = ~dec(nib);
      dp  = ~p[d];
    end
    return {an, seg, dp, 3'(d), fs};
  endfunction

  function automatic logic [19:0] obs8();
    return {bus8.an_out, bus8.seg_out, bus8.dp_out, bus8.digit_idx, bus8.frame_start};
  endfunction

  function automatic logic [14:0] obs4();
    return {bus4.an_out, bus4.seg_out, bus4.dp_out, bus4.digit_idx, bus4.frame_start};
  endfunction

  task automatic tick();
    @(posedge clk_out);
    #1;
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    #2;
    checks++;
    if (obs8() !== Off8) begin
      errors++; $display("FAIL reset8 got %h exp %h", obs8(), Off8);
    end
    checks++;
    if (obs4() !== Off4) begin
      errors++; $display("FAIL reset4 got %h exp %h", obs4(), Off4);
    end
    tick();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (obs8() !== Off8) begin
      errors++; $display("FAIL idle_disabled got %h exp %h", obs8(), Off8);
    end
  endtask

  task automatic test_scan();
    int c0;
    bus8.binary_in = 32'h01234567; bus8.digit_mask = 8'hFF; bus8.dp_in = 8'h00;
    bus8.enable = 1'b1;
    tick();
    checks++;
    if (obs8() !== Off8) begin
      errors++; $display("FAIL scan_load got %h exp %h", obs8(), Off8);
    end
    tick();
    c0 = cyc;
    for (int d = 0; d < 8; d++) begin
      for (int t = 0; t < 18; t++) begin
        checks++;
        if (obs8() !== exp_vec(32'h01234567, 8'hFF, 8'h00, d, t >= 16, d == 0 && t == 0)) begin
          errors++;
          $display("FAIL scan d%0d t%0d got %h exp %h", d, t, obs8(),
                   exp_vec(32'h01234567, 8'hFF, 8'h00, d, t >= 16, d == 0 && t == 0));
        end
        tick();
      end
    end
    checks++;
    if (obs8() !== Off8) begin
      errors++; $display("FAIL scan_reload got %h exp %h", obs8(), Off8);
    end
    tick();
    checks++;
    if (bus8.frame_start !== 1'b1 || cyc - c0 !== 145) begin
      errors++;
      $display("FAIL frame_period got fs=%b period=%0d exp fs=1 period=145",
               bus8.frame_start, cyc - c0);
    end
  endtask

  task automatic test_snapshot();
    for (int d = 0; d < 8; d++) begin
      for (int t = 0; t < 18; t++) begin
        if (d == 3 && t == 0) bus8.binary_in = 32'hFFFFFFFF;
        checks++;
        if (obs8() !== exp_vec(32'h01234567, 8'hFF, 8'h00, d, t >= 16, d == 0 && t == 0)) begin
          errors++;
          $display("FAIL snap_old d%0d t%0d got %h exp %h", d, t, obs8(),
                   exp_vec(32'h01234567, 8'hFF, 8'h00, d, t >= 16, d == 0 && t == 0));
        end
        tick();
      end
    end
    tick();
    for (int d = 0; d < 8; d++) begin
      for (int t = 0; t < 18; t++) begin
        // Mid-frame mask/dp change must wait for the next snapshot.
        if (d == 0 && t == 1) begin
          bus8.digit_mask = 8'h0F; bus8.dp_in = 8'h01;
        end
        checks++;
        if (obs8() !== exp_vec(32'hFFFFFFFF, 8'hFF, 8'h00, d, t >= 16, d == 0 && t == 0)) begin
          errors++;
          $display("FAIL snap_new d%0d t%0d got %h exp %h", d, t, obs8(),
                   exp_vec(32'hFFFFFFFF, 8'hFF, 8'h00, d, t >= 16, d == 0 && t == 0));
        end
        tick();
      end
    end
    tick();
  endtask

  task automatic test_mask();
    for (int d = 0; d < 8; d++) begin
      for (int t = 0; t < 18; t++) begin
        checks++;
        if (obs8() !== exp_vec(32'hFFFFFFFF, 8'h0F, 8'h01, d, t >= 16, d == 0 && t == 0)) begin
          errors++;
          $display("FAIL mask d%0d t%0d got %h exp %h", d, t, obs8(),
                   exp_vec(32'hFFFFFFFF, 8'h0F, 8'h01, d, t >= 16, d == 0 && t == 0));
        end
        tick();
      end
    end
    tick();
  endtask

  task automatic test_enable();
    for (int d = 0; d < 8; d++) begin
      for (int t = 0; t < 18; t++) begin
        if (d == 2 && t == 0) bus8.enable = 1'b0;
        checks++;
        if (obs8() !== exp_vec(32'hFFFFFFFF, 8'h0F, 8'h01, d, t >= 16, d == 0 && t == 0)) begin
          errors++;
          $display("FAIL en_drain d%0d t%0d got %h exp %h", d, t, obs8(),
                   exp_vec(32'hFFFFFFFF, 8'h0F, 8'h01, d, t >= 16, d == 0 && t == 0));
        end
        tick();
      end
    end
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (obs8() !== Off8) begin
        errors++; $display("FAIL en_idle i%0d got %h exp %h", i, obs8(), Off8);
      end
      tick();
    end
    bus8.enable = 1'b1;
    tick();
    checks++;
    if (obs8() !== Off8) begin
      errors++; $display("FAIL en_load got %h exp %h", obs8(), Off8);
    end
    tick();
    checks++;
    if (obs8() !== exp_vec(32'hFFFFFFFF, 8'h0F, 8'h01, 0, 1'b0, 1'b1)) begin
      errors++;
      $display("FAIL en_restart got %h exp %h", obs8(),
               exp_vec(32'hFFFFFFFF, 8'h0F, 8'h01, 0, 1'b0, 1'b1));
    end
  endtask

  task automatic test_reset_mid();
    tick();
    tick();
    tick();
    #3 reset = 1'b0;
    #1;
    checks++;
    if (obs8() !== Off8) begin
      errors++; $display("FAIL rst_async got %h exp %h", obs8(), Off8);
    end
    @(posedge clk_out);
    #1;
    checks++;
    if (obs8() !== Off8) begin
      errors++; $display("FAIL rst_held got %h exp %h", obs8(), Off8);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (obs8() !== Off8) begin
      errors++; $display("FAIL rst_load got %h exp %h", obs8(), Off8);
    end
    tick();
    checks++;
    if (obs8() !== exp_vec(32'hFFFFFFFF, 8'h0F, 8'h01, 0, 1'b0, 1'b1)) begin
      errors++;
      $display("FAIL rst_restart got %h exp %h", obs8(),
               exp_vec(32'hFFFFFFFF, 8'h0F, 8'h01, 0, 1'b0, 1'b1));
    end
  endtask

  task automatic test_back_to_back();
    int          c0;
    logic [14:0] e;
    logic [3:0]  one;
    logic [15:0] w;
    w = 16'h1234;
    bus4.binary_in = w; bus4.digit_mask = 4'hF; bus4.dp_in = 4'h0; bus4.enable = 1'b1;
    tick();
    checks++;
    if (obs4() !== Off4) begin
      errors++; $display("FAIL b2b_load got %h exp %h", obs4(), Off4);
    end
    tick();
    c0 = cyc;
    for (int d = 0; d < 4; d++) begin
      for (int t = 0; t < 4; t++) begin
        one = 4'h1 << d;
        e = {~one, ~dec(w[4*d +: 4]), 1'b1, 2'(d), (d == 0 && t == 0) ? 1'b1 : 1'b0};
        checks++;
        if (obs4() !== e) begin
          errors++; $display("FAIL b2b d%0d t%0d got %h exp %h", d, t, obs4(), e);
        end
        tick();
      end
    end
    checks++;
    if (obs4() !== Off4) begin
      errors++; $display("FAIL b2b_reload got %h exp %h", obs4(), Off4);
    end
    tick();
    checks++;
    if (bus4.frame_start !== 1'b1 || cyc - c0 !== 17) begin
      errors++;
      $display("FAIL b2b_period got fs=%b period=%0d exp fs=1 period=17",
               bus4.frame_start, cyc - c0);
    end
  endtask

  initial begin
    bus8.enable = 1'b0; bus8.binary_in = '0; bus8.digit_mask = '0; bus8.dp_in = '0;
    bus4.enable = 1'b0; bus4.binary_in = '0; bus4.digit_mask = '0; bus4.dp_in = '0;
    test_reset();
    test_scan();
    test_snapshot();
    test_mask();
    test_enable();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
